// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, FSM states and instruction field positions for the cpu core
package cpu_pkg;

  localparam logic [4:0] OP_LDI  = 5'b00000;
  localparam logic [4:0] OP_LDIH = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUBI = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b01001;
  localparam logic [4:0] OP_ADD  = 5'b01010;
  localparam logic [4:0] OP_SUB  = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_SHL  = 5'b01101;
  localparam logic [4:0] OP_SHR  = 5'b01110;
  localparam logic [4:0] OP_NOT  = 5'b01111;
  localparam logic [4:0] OP_JMP  = 5'b10000;
  localparam logic [4:0] OP_JZ   = 5'b10001;
  localparam logic [4:0] OP_JR   = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 5;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_t;

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU: result, zero test and register write-enable per opcode
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [7:0]        imm,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              writes_rd
);

  logic [DATA_W-1:0] imm_ext;

  assign imm_ext = {{(DATA_W-8){1'b0}}, imm};

  always_comb begin
    result    = a;
    writes_rd = 1'b1;
    case (op)
      OP_LDI:  result = imm_ext;
      OP_LDIH: result = {imm, a[7:0]};
      OP_ADDI: result = a + imm_ext;
      OP_SUBI: result = a - imm_ext;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << 1;
      OP_SHR:  result = a >> 1;
      OP_NOT:  result = ~a;
      default: writes_rd = 1'b0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - multi-cycle 16-bit register CPU: fetch/decode/exec/writeback FSM with inline register file
module cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic              en_ram_out,
  input  logic [DATA_W-1:0] ins,
  output logic              en_ram_in,
  output logic [DATA_W-1:0] addr
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              zf_q, zf_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic              wr_q, wr_d;
  logic              setz_q, setz_d;
  logic              taken_q, taken_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic              halt_q, halt_d;

  logic [4:0]        op;
  logic [2:0]        rd;
  logic [2:0]        rs;
  logic [7:0]        imm;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_writes;

  assign op      = ir_q[OP_HI:OP_LO];
  assign rd      = ir_q[RD_HI:RD_LO];
  assign rs      = ir_q[RS_HI:RS_LO];
  assign imm     = ir_q[IMM_HI:IMM_LO];
  assign imm_ext = {{(DATA_W-8){1'b0}}, imm};

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (op),
    .a         (a_q),
    .b         (b_q),
    .imm       (imm),
    .result    (alu_result),
    .zero      (alu_zero),
    .writes_rd (alu_writes)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    regs_d   = regs_q;
    zf_d     = zf_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    zero_d   = zero_q;
    wr_d     = wr_q;
    setz_d   = setz_q;
    taken_d  = taken_q;
    target_d = target_q;
    halt_d   = halt_q;
    case (state_q)
      ST_IDLE: begin
        // a halted core ignores en_in until the next reset
        if (en_in && !halt_q) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!en_in) begin
          state_d = ST_IDLE;
        end else if (en_ram_out) begin
          ir_d    = ins;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d     = regs_q[rd];
        b_d     = regs_q[rs];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d    = alu_result;
        zero_d   = alu_zero;
        wr_d     = alu_writes;
        setz_d   = alu_writes && (op != OP_LDI) && (op != OP_LDIH);
        taken_d  = 1'b0;
        target_d = imm_ext;
        case (op)
          OP_JMP: taken_d = 1'b1;
          OP_JZ:  taken_d = zf_q;
          OP_JR: begin
            taken_d  = 1'b1;
            target_d = a_q;
          end
          default: taken_d = 1'b0;
        endcase
        state_d = ST_WB;
      end
      ST_WB: begin
        if (wr_q) regs_d[rd] = res_q;
        if (setz_q) zf_d = zero_q;
        if (op == OP_HALT) begin
          halt_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          pc_d    = taken_q ? target_q : pc_q + DATA_W'(1);
          state_d = en_in ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      zf_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      wr_q     <= 1'b0;
      setz_q   <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      regs_q   <= regs_d;
      zf_q     <= zf_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      wr_q     <= wr_d;
      setz_q   <= setz_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      halt_q   <= halt_d;
    end
  end

  assign en_ram_in = (state_q == ST_FETCH);
  assign addr      = pc_q;

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - directed self-checking bench for the cpu core
module tb_cpu;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        en_in;
  logic        en_ram_out;
  logic [15:0] ins;
  logic        en_ram_in;
  logic [15:0] addr;

  int n_checks;
  int n_errors;
  int pulses;

  cpu #(.DATA_W(16), .NREG(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_in      (en_in),
    .en_ram_out (en_ram_out),
    .ins        (ins),
    .en_ram_in  (en_ram_in),
    .addr       (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ins(input logic [15:0] w);
    ins = w;
    for (int c = 0; c < 4; c++) begin
      pulses += int'(en_ram_in);
      tick();
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    pulses     = 0;
    rst        = 1'b1;
    en_in      = 1'b0;
    en_ram_out = 1'b0;
    ins        = 16'h0000;
    #3 rst = 1'b0;
    repeat (3) tick();
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_en_ram_in", 32'(en_ram_in), 32'h0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), 32'(dut.regs_q[i]), 32'h0);

    // LDI r0,#1 held for three instructions
    rst = 1'b1;
    tick();
    en_in = 1'b1;
    en_ram_out = 1'b1;
    ins = 16'h0001;
    tick();
    check("first_fetch_req", 32'(en_ram_in), 32'h1);
    check("first_fetch_addr", 32'(addr), 32'h0);
    pulses = 0;
    do_ins(16'h0001);
    check("addr_step1", 32'(addr), 32'h1);
    do_ins(16'h0001);
    check("addr_step2", 32'(addr), 32'h2);
    do_ins(16'h0001);
    check("pulses_1_in_4", 32'(pulses), 32'd3);
    check("addr_step3", 32'(addr), 32'h3);
    check("ldi_r0", 32'(dut.regs_q[0]), 32'h1);

    do_ins(16'h0402);
    do_ins(16'h2803);
    do_ins(16'h2803);
    do_ins(16'h2803);
    check("addi_r0", 32'(dut.regs_q[0]), 32'h000A);
    check("ldi_r4", 32'(dut.regs_q[4]), 32'h0002);
    check("addi_zf", 32'(dut.zf_q), 32'h0);
    check("addr_7", 32'(addr), 32'h7);

    do_ins(16'h5100);
    check("add_r1", 32'(dut.regs_q[1]), 32'h000A);
    do_ins(16'h310A);
    check("subi_r1", 32'(dut.regs_q[1]), 32'h0);
    check("subi_zf", 32'(dut.zf_q), 32'h1);
    do_ins(16'h8820);
    check("jz_taken", 32'(addr), 32'h0020);
    do_ins(16'h2801);
    check("addi_r0_b", 32'(dut.regs_q[0]), 32'h000B);
    check("addi_zf_clr", 32'(dut.zf_q), 32'h0);
    do_ins(16'h8820);
    check("jz_not_taken", 32'(addr), 32'h0022);

    do_ins(16'h7E00);
    check("not_r6", 32'(dut.regs_q[6]), 32'hFFFF);
    do_ins(16'h9600);
    check("jr_addr", 32'(addr), 32'hFFFF);
    do_ins(16'h3800);
    check("pc_wrap", 32'(addr), 32'h0000);

    // rd==rs reads old value; loads leave zf untouched
    do_ins(16'h66C0);
    check("xor_self_r6", 32'(dut.regs_q[6]), 32'h0);
    check("xor_zf", 32'(dut.zf_q), 32'h1);
    do_ins(16'h0255);
    do_ins(16'h0AAB);
    check("ldih_r2", 32'(dut.regs_q[2]), 32'hAB55);
    check("load_keeps_zf", 32'(dut.zf_q), 32'h1);
    do_ins(16'h7200);
    check("shr_r2", 32'(dut.regs_q[2]), 32'h55AA);
    check("shr_zf", 32'(dut.zf_q), 32'h0);
    do_ins(16'h6A00);
    check("shl_r2", 32'(dut.regs_q[2]), 32'hAB54);
    do_ins(16'h4C00);
    check("or_r4", 32'(dut.regs_q[4]), 32'h000B);
    do_ins(16'h4440);
    check("and_r4", 32'(dut.regs_q[4]), 32'h0);
    check("and_zf", 32'(dut.zf_q), 32'h1);
    do_ins(16'h5840);
    check("sub_r0", 32'(dut.regs_q[0]), 32'h54B7);
    do_ins(16'h8040);
    check("jmp_addr", 32'(addr), 32'h0040);
    check("jmp_keeps_zf", 32'(dut.zf_q), 32'h0);

    // RAM stall, then en_in drop while waiting
    en_ram_out = 1'b0;
    repeat (5) tick();
    check("stall_state", 32'(dut.state_q), 32'(ST_FETCH));
    check("stall_req", 32'(en_ram_in), 32'h1);
    check("stall_addr", 32'(addr), 32'h0040);
    en_in = 1'b0;
    tick();
    check("drop_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("drop_req", 32'(en_ram_in), 32'h0);

    en_in = 1'b1;
    en_ram_out = 1'b1;
    tick();
    do_ins(16'hF800);
    check("halt_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("halt_addr", 32'(addr), 32'h0040);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      pulses += int'(en_ram_in);
      tick();
    end
    check("halt_no_fetch", 32'(pulses), 32'd0);

    // en_in dropped after fetch still completes the instruction
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("post_halt_fetch", 32'(en_ram_in), 32'h1);
    ins = 16'h0509;
    tick();
    en_in = 1'b0;
    repeat (3) tick();
    check("late_drop_r5", 32'(dut.regs_q[5]), 32'h0009);
    check("late_drop_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("late_drop_addr", 32'(addr), 32'h0001);

    // asynchronous reset in the middle of EXEC
    en_in = 1'b1;
    tick();
    ins = 16'h0377;
    repeat (2) tick();
    check("mid_exec_state", 32'(dut.state_q), 32'(ST_EXEC));
    #2 rst = 1'b0;
    #1;
    check("async_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("async_addr", 32'(addr), 32'h0);
    check("async_req", 32'(en_ram_in), 32'h0);
    check("async_r5", 32'(dut.regs_q[5]), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- 16-bit multi-cycle accumulator/register CPU core with 8 general registers, a 16-bit PC and a zero flag.
- Fetches one instruction word per instruction from an external instruction RAM.
  - Address is presented on addr; a fetch request is signalled on en_ram_in.
  - The instruction word is accepted on ins when en_ram_out (RAM data valid) is high.
- Top-level compute block of the system, sitting between the instruction RAM and the system controller that drives en_in.

Parameters:
- DATA_W, 16, datapath, register, ins and addr width.
- NREG, 8, number of general registers r0..r7 (3-bit index).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- en_in  in  1  CPU run enable
- en_ram_out  in  1  instruction RAM data valid; ins is sampled only when high
- ins  in  16  instruction word from RAM
- en_ram_in  out  1  instruction fetch request to RAM
- addr  out  16  fetch address, always equals PC

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, PC=0, IR=0, r0..r7=0, zf=0, en_ram_in=0, addr=0.
- Instruction fields:
  - op=ins[15:11], rd=ins[10:8], rs=ins[7:5], imm8=ins[7:0].
  - imm8 is zero-extended to 16 bits.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB. All outputs are registered or decoded from state.
  - IDLE: en_ram_in=0. If en_in=1, go to FETCH.
  - FETCH: en_ram_in=1, addr=PC.
    - en_in=0: go to IDLE; no instruction is issued.
    - en_ram_out=1: IR<=ins, go to DECODE.
    - otherwise stay in FETCH (stall indefinitely).
  - DECODE: read operands rd and rs, go to EXEC.
  - EXEC: compute the ALU result and the branch target, go to WB.
  - WB: write rd and update zf if the opcode writes.
    - PC <= branch target if taken, else PC+1 (mod 2^16).
    - Then go to FETCH if en_in=1, else IDLE.
- Throughput: 4 clocks per instruction when en_ram_out is held 1. en_ram_in is high exactly 1 cycle in 4.
- A de-asserted en_in after FETCH does not abort the instruction; it completes through WB.
- Opcodes; all arithmetic is mod 2^16, no carry:
  - 00000 LDI: rd = {8'h00, imm8}
  - 00001 LDIH: rd = {imm8, rd[7:0]}
  - 00101 ADDI: rd = rd + imm8
  - 00110 SUBI: rd = rd − imm8
  - 01000 AND: rd = rd & rs
  - 01001 OR: rd = rd | rs
  - 01010 ADD: rd = rd + rs
  - 01011 SUB: rd = rd − rs
  - 01100 XOR: rd = rd ^ rs
  - 01101 SHL: rd = rd << 1
  - 01110 SHR: rd = rd >> 1 (logical)
  - 01111 NOT: rd = ~rd
  - 10000 JMP: PC = imm8
  - 10001 JZ: PC = imm8 if zf=1, else PC+1
  - 10010 JR: PC = rd
  - 11111 HALT: PC is not advanced, and the FSM returns to IDLE and stays there until reset.
  - All other opcodes: NOP (PC+1, no writes).
- zf: set to (result==0) by ALU ops 00101–01111 only. Loads, jumps and NOP leave zf unchanged.
- Self-referencing ops (rd==rs) read the old value.

Decomposition:
- Package cpu_pkg:
  - opcode localparams (OP_LDI … OP_HALT);
  - FSM state enum;
  - field position constants.
- One sub-module cpu_alu: combinational; inputs op, a, b, imm; outputs result, zero, writes_rd. The register file stays inline in cpu.

Test Plan:
- Reset: hold rst=0 with clocks running → addr=0x0000, en_ram_in=0, all regs 0. Assert rst=0 mid-EXEC → immediate return to these values.
- en_in=1, en_ram_out=1, ins=0x0001 (LDI r0,#1) held → en_ram_in pulses 1 of every 4 cycles; addr steps 0,1,2,…; r0=0x0001.
- ins=0x0402 (LDI r4,#2), then 0x2803 (ADDI r0,#3) held 3 instructions starting from r0=1 → r0=0x000A, r4=0x0002, zf=0.
- ins=0x5100 (ADD r1,r1+r0) with r0=0x000A, r1=0 → r1=0x000A.
  - Then SUBI r1,#10 (0x310A) → r1=0x0000, zf=1.
  - Then JZ #0x20 (0x8820) → next addr=0x0020.
- ins=0x7E00 (NOT r6) → r6=0xFFFF. Then 0x9600 (JR r6) → next fetch addr=0xFFFF, following addr=0x0000 (wrap).
- en_ram_out=0 during FETCH for 5 cycles → state holds FETCH, en_ram_in=1, addr unchanged. en_in=0 then → IDLE, en_ram_in=0. HALT (0xF800) → no further fetches.
